// File: rtl/gray_pkg.sv
// Shared Gray-code constants and width-parametrised conversion helpers.
// Helpers work on zero-extended 32-bit values; the width argument masks the live bits.
package gray_pkg;

    localparam int unsigned GRAY_DEFAULT_WIDTH = 4;
    localparam int unsigned GRAY_MAX_WIDTH     = 32;

    function automatic logic [31:0] width_mask(input int unsigned width);
        logic [31:0] mask;
        if (width >= GRAY_MAX_WIDTH) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return mask;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
        logic [31:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR running down from the MSB of the live width.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] b;
        logic        acc;
        b   = 32'd0;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc  = acc ^ gray[i];
                b[i] = acc;
            end else begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Purely combinational Gray-to-binary decoder, reusable wherever a Gray word must be decoded.
module gray_to_binary
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(gray2bin(32'(gray_i), WIDTH));

endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding a binary count, with registered Gray and binary views and a wrap pulse.
// gray_out comes straight from its own flop so it can be sampled safely in another clock domain.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned      WIDTH = GRAY_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(32'(INIT), WIDTH));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] load_bin_s;

    gray_to_binary #(
        .WIDTH (WIDTH)
    ) u_load_dec (
        .gray_i (load_gray),
        .bin_o  (load_bin_s)
    );

    // Next count: load beats step beats hold; wrap flags only a step across the end of the range.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin_s;
            wrap_d = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + CNT_ONE;
                wrap_d = (bin_q == CNT_MAX);
            end else begin
                bin_d  = bin_q - CNT_ONE;
                wrap_d = (bin_q == CNT_ZERO);
            end
        end else begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
        end
        gray_d = WIDTH'(bin2gray(32'(bin_d), WIDTH));
    end

    // Count, Gray and wrap registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= INIT;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed vector table, hand sequences, and random traffic against a count model.
module tb_gray_counter;

    logic       clk;
    logic       rst_n, en, up_dn, load;
    logic [3:0] load_gray, gray_out, bin_out;
    logic       wrap;

    logic       rst_n8, en8, up8, load8;
    logic [7:0] lg8, gray8, bin8;
    logic       wrap8;

    int n_vec;
    int n_miss;
    int m_bin;
    int m_wrap;

    typedef struct {
        logic       rst_n;
        logic       load;
        logic       en;
        logic       up_dn;
        logic [3:0] lg;
        logic [3:0] eb;
        logic [3:0] eg;
        logic       ew;
    } vec_t;

    vec_t tbl[$];

    gray_counter #(.WIDTH(4), .INIT(4'd0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .gray_out(gray_out), .bin_out(bin_out), .wrap(wrap)
    );

    gray_counter #(.WIDTH(8), .INIT(8'd200)) dut8 (
        .clk(clk), .rst_n(rst_n8), .en(en8), .up_dn(up8), .load(load8),
        .load_gray(lg8), .gray_out(gray8), .bin_out(bin8), .wrap(wrap8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int g_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: count kept as an integer modulo 16, load decoded by searching for the matching code.
    task automatic model_edge(input logic r, input logic l, input logic e, input logic u, input logic [3:0] lg);
        if (!r) begin
            m_bin  = 0;
            m_wrap = 0;
        end else if (l) begin
            for (int k = 0; k < 16; k++) begin
                if (g_of(k) == int'(lg)) m_bin = k;
            end
            m_wrap = 0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin == 15) ? 1 : 0;
                m_bin  = (m_bin + 1) % 16;
            end else begin
                m_wrap = (m_bin == 0) ? 1 : 0;
                m_bin  = (m_bin + 15) % 16;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [3:0] lg);
        rst_n     = r;
        load      = l;
        en        = e;
        up_dn     = u;
        load_gray = lg;
        @(posedge clk);
        #1;
        model_edge(r, l, e, u, lg);
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic u, input logic [3:0] lg,
                       input int eb, input int eg, input logic ew);
        vec_t v;
        v.rst_n = r; v.load = l; v.en = e; v.up_dn = u; v.lg = lg;
        v.eb = 4'(eb); v.eg = 4'(eg); v.ew = ew;
        tbl.push_back(v);
    endtask

    initial begin
        logic       r, l, e, u;
        logic [3:0] lg, prev_g;

        n_vec = 0; n_miss = 0; m_bin = 0; m_wrap = 0;
        rst_n = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_gray = 4'd0;
        rst_n8 = 1'b0; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; lg8 = 8'd0;

        // Reset, second cycle with load/en also asserted
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 0, 0, 1'b0);
        // Sixteen up-steps from 0 through 15 and back to 0
        for (int k = 1; k <= 16; k++) add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, k % 16, g_of(k % 16), k == 16);
        // Down-wrap from 0
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 15, 4'b1000, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 14, 4'b1001, 1'b0);
        // Load priority over en, no wrap on load, wrap after loading 15 and stepping up
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 3, 4'b0010, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 9, 4'b1101, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 15, 4'b1000, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 0, 0, 1'b1);
        // Hold for five cycles
        for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b0, 1'(k % 2), 4'h0, 0, 0, 1'b0);
        // Alternating direction from 7
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 7, 4'b0100, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 8, 4'b1100, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 7, 4'b0100, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 8, 4'b1100, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 7, 4'b0100, 1'b0);
        // Reset mid-count at 9 with load and en asserted, then resume
        add(1'b1, 1'b1, 1'b0, 1'b0, 4'b1101, 9, 4'b1101, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 0, 0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1, 4'b0001, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].load, tbl[i].en, tbl[i].up_dn, tbl[i].lg);
            chk($sformatf("tbl%0d_bin", i),  32'(bin_out),  32'(tbl[i].eb));
            chk($sformatf("tbl%0d_gray", i), 32'(gray_out), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_wrap", i), 32'(wrap),     32'(tbl[i].ew));
        end

        // Reset pulse that starts and ends between edges must do nothing
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        #2 rst_n = 1'b0;
        #2;
        chk("glitch_hold_bin", 32'(bin_out), 32'd1);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
        chk("glitch_step_bin",  32'(bin_out),  32'd2);
        chk("glitch_step_gray", 32'(gray_out), 32'(4'b0011));

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            prev_g = gray_out;
            r  = ($urandom_range(0, 19) != 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom_range(0, 1));
            lg = 4'($urandom_range(0, 15));
            drive(r, l, e, u, lg);
            chk($sformatf("rnd%0d_bin", i),  32'(bin_out),  32'(m_bin));
            chk($sformatf("rnd%0d_gray", i), 32'(gray_out), 32'(g_of(m_bin)));
            chk($sformatf("rnd%0d_wrap", i), 32'(wrap),     32'(m_wrap));
            if (r && !l && e) begin
                chk($sformatf("rnd%0d_onebit", i), 32'($countones(gray_out ^ prev_g)), 32'd1);
            end
        end

        // Wide instance with a non-zero reset value, held in reset since time zero
        chk("w8_rst_bin",  32'(bin8),  32'h0000_00C8);
        chk("w8_rst_gray", 32'(gray8), 32'h0000_00AC);
        chk("w8_rst_wrap", 32'(wrap8), 32'd0);
        rst_n8 = 1'b1;
        en8    = 1'b1;
        up8    = 1'b1;
        @(posedge clk);
        #1;
        chk("w8_step_bin",  32'(bin8),  32'd201);
        chk("w8_step_gray", 32'(gray8), 32'(201 ^ (201 >> 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
